simple_formal_alu: RTL and testbench
====================================

// Module: simple_formal_alu
// PURPOSE
//   Registered 64-bit two-operand arithmetic/compare unit, used as a formal-verification
//   target. It computes ADD/SUB/signed-MAX/signed-MIN on a and b with status flags, one
//   cycle after the operands are presented. It raises a sticky match flag when a SUB
//   result equals a programmable target, which gives the formal flow its cover goal.
// PARAMETERS
//   WIDTH        64                      operand/result width in bits
//   COVER_VALUE  64'h0000_0000_0000_AAAA SUB result that sets cover_hit
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      reset: synchronous, active-high
//   in_valid   in   1      a, b and op are sampled on this cycle
//   op         in   2      00 ADD, 01 SUB, 10 MAX (signed), 11 MIN (signed)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   out_valid  out  1      result/flags valid (one cycle after in_valid)
//   result     out  WIDTH  operation result
//   carry      out  1      ADD: carry-out; SUB: borrow (a <u b); MAX/MIN: 0
//   overflow   out  1      signed overflow for ADD/SUB; 0 for MAX/MIN
//   zero       out  1      result == 0
//   negative   out  1      result[WIDTH-1]
//   a_eq_b     out  1      a == b (registered with result)
//   cover_hit  out  1      sticky: a SUB result has equalled COVER_VALUE
// BEHAVIOUR
//   - Reset (clk edge with rst=1): every output is 0, including cover_hit.
//     rst has priority over in_valid on the same edge.
//   - Latency is 1: on an edge with in_valid=1 and rst=0, all outputs update from
//     that cycle's a/b/op and out_valid is 1 for exactly the next cycle. A new
//     operation may be issued every cycle; there is no backpressure.
//   - in_valid=0: out_valid is 0 next cycle. result and the flags hold their last
//     values. cover_hit never clears except on rst.
//   - ADD: {carry,result} = a + b (WIDTH+1-bit). overflow = (a[MSB]==b[MSB]) &&
//     (result[MSB]!=a[MSB]).
//   - SUB: result = a - b mod 2^WIDTH. carry = (a <u b). overflow = (a[MSB]!=b[MSB])
//     && (result[MSB]!=a[MSB]).
//   - MAX/MIN: the signed two's-complement compare selects a or b. On a tie the
//     result is a.
//   - cover_hit goes to 1 on the edge where a valid SUB yields result==COVER_VALUE.
//     It is visible the same cycle as that result.
//   - The arithmetic is fully combinational between the input sample and the output
//     register. Operands are sampled directly, with no input register.
// TESTING
//   1. Reset: hold rst=1 for 2 cycles with in_valid=1 -> every output is 0, including
//      out_valid and cover_hit.
//   2. SUB cover: a=0, b=64'hFFFF_FFFF_FFFF_5556, op=01 -> result=64'hAAAA, carry=1,
//      overflow=0, zero=0, negative=0, cover_hit=1 and stays 1 until rst.
//   3. ADD: a=0, b=64'hFFFF_FFFF_FFFF_5556, op=00 -> result=b, negative=1, carry=0.
//      Then a=b=64'h7FFF_FFFF_FFFF_FFFF -> result=64'hFFFF_FFFF_FFFF_FFFE, overflow=1.
//   4. ADD wrap: a=64'hFFFF_FFFF_FFFF_FFFF, b=1 -> result=0, zero=1, carry=1,
//      overflow=0.
//   5. MAX/MIN: a=64'h8000_0000_0000_0000, b=1 -> MAX gives 1, MIN gives a.
//      With a=b=5 -> a_eq_b=1 and result=5.
//   6. Back-to-back: issue ops on 3 consecutive cycles, then drop in_valid ->
//      out_valid is 1,1,1,0 and result holds the third value afterwards.

Source files
------------

// File: rtl/simple_formal_alu.sv
// Registered two-operand ADD/SUB/signed-MAX/signed-MIN unit with status flags
// and a sticky match flag raised when a SUB result equals COVER_VALUE.
module simple_formal_alu #(
    parameter int unsigned       WIDTH       = 64,
    parameter logic [WIDTH-1:0]  COVER_VALUE = WIDTH'(64'h0000_0000_0000_AAAA)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             a_eq_b,
    output logic             cover_hit
);

    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MAX = 2'b10;
    localparam logic [1:0] OP_MIN = 2'b11;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;
    logic             w_a_ge_b;
    logic             w_a_le_b;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_overflow;
    logic             w_cover;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_overflow;
    logic             r_zero;
    logic             r_negative;
    logic             r_a_eq_b;
    logic             r_cover_hit;

    // Shared arithmetic and signed compares feeding the result mux
    always_comb begin
        w_sum    = {1'b0, a} + {1'b0, b};
        w_diff   = a - b;
        w_borrow = (a < b);
        w_a_ge_b = ($signed(a) >= $signed(b));
        w_a_le_b = ($signed(a) <= $signed(b));
    end

    // Select result and per-op flags; ties in MAX/MIN resolve to a
    always_comb begin
        w_result   = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        w_cover    = 1'b0;
        case (op)
            OP_ADD: begin
                w_result   = w_sum[WIDTH-1:0];
                w_carry    = w_sum[WIDTH];
                w_overflow = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                w_result   = w_diff;
                w_carry    = w_borrow;
                w_overflow = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
                w_cover    = (w_diff == COVER_VALUE);
            end
            OP_MAX: begin
                w_result = w_a_ge_b ? a : b;
            end
            OP_MIN: begin
                w_result = w_a_le_b ? a : b;
            end
            default: begin
                w_result = '0;
            end
        endcase
    end

    // Output register: flags hold when idle, cover_hit is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
            r_a_eq_b    <= 1'b0;
            r_cover_hit <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result    <= w_result;
                r_carry     <= w_carry;
                r_overflow  <= w_overflow;
                r_zero      <= (w_result == '0);
                r_negative  <= w_result[MSB];
                r_a_eq_b    <= (a == b);
                r_cover_hit <= r_cover_hit | w_cover;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign zero      = r_zero;
    assign negative  = r_negative;
    assign a_eq_b    = r_a_eq_b;
    assign cover_hit = r_cover_hit;

endmodule

// File: tb/tb_simple_formal_alu.sv
// Directed-vector bench for simple_formal_alu with hand-computed expectations.
module tb_simple_formal_alu;

    localparam int unsigned WIDTH = 64;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic             a_eq_b;
    logic             cover_hit;

    int checks;
    int failures;

    simple_formal_alu #(
        .WIDTH       (WIDTH),
        .COVER_VALUE (64'h0000_0000_0000_AAAA)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .a_eq_b    (a_eq_b),
        .cover_hit (cover_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one operation and sample outputs 1 time unit after the capturing edge
    task automatic issue(input logic [1:0] i_op, input logic [63:0] i_a, input logic [63:0] i_b);
        in_valid = 1'b1;
        op       = i_op;
        a        = i_a;
        b        = i_b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic c, input logic ov,
                               input logic z, input logic n, input logic eq);
        check({tag, ".carry"},    64'(carry),    64'(c));
        check({tag, ".overflow"}, 64'(overflow), 64'(ov));
        check({tag, ".zero"},     64'(zero),     64'(z));
        check({tag, ".negative"}, 64'(negative), 64'(n));
        check({tag, ".a_eq_b"},   64'(a_eq_b),   64'(eq));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        in_valid = 1'b1;
        op       = 2'b01;
        a        = 64'd0;
        b        = 64'hFFFF_FFFF_FFFF_5556;

        // Reset held 2 cycles with a valid cover-hitting SUB presented
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.result",    result,         64'd0);
        check("rst.cover_hit", 64'(cover_hit), 64'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst.out_valid", 64'(out_valid), 64'd0);

        // ADD giving the cover value must not set cover_hit
        issue(2'b00, 64'h0000_0000_0000_AAAA, 64'd0);
        check("add_cv.result",    result,         64'h0000_0000_0000_AAAA);
        check("add_cv.cover_hit", 64'(cover_hit), 64'd0);
        idle_cycle();

        // SUB cover
        issue(2'b01, 64'd0, 64'hFFFF_FFFF_FFFF_5556);
        check("sub.out_valid", 64'(out_valid), 64'd1);
        check("sub.result",    result,         64'h0000_0000_0000_AAAA);
        check("sub.cover_hit", 64'(cover_hit), 64'd1);
        check_flags("sub", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        check("sub_idle.out_valid", 64'(out_valid), 64'd0);
        check("sub_idle.result",    result,         64'h0000_0000_0000_AAAA);

        // ADD with negative result
        issue(2'b00, 64'd0, 64'hFFFF_FFFF_FFFF_5556);
        check("add_neg.result", result, 64'hFFFF_FFFF_FFFF_5556);
        check_flags("add_neg", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("add_neg.cover_hit", 64'(cover_hit), 64'd1);

        // ADD signed overflow
        issue(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
        check("add_ovf.result", result, 64'hFFFF_FFFF_FFFF_FFFE);
        check_flags("add_ovf", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

        // ADD wrap to zero
        issue(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check("add_wrap.result", result, 64'd0);
        check_flags("add_wrap", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // SUB signed overflow: min_int - 1
        issue(2'b01, 64'h8000_0000_0000_0000, 64'd1);
        check("sub_ovf.result", result, 64'h7FFF_FFFF_FFFF_FFFF);
        check_flags("sub_ovf", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Signed MAX/MIN
        issue(2'b10, 64'h8000_0000_0000_0000, 64'd1);
        check("max.result", result, 64'd1);
        check_flags("max", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(2'b11, 64'h8000_0000_0000_0000, 64'd1);
        check("min.result", result, 64'h8000_0000_0000_0000);
        check_flags("min", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(2'b10, 64'd5, 64'd5);
        check("max_tie.result", result, 64'd5);
        check("max_tie.a_eq_b", 64'(a_eq_b), 64'd1);
        issue(2'b11, 64'd5, 64'd5);
        check("min_tie.result", result, 64'd5);
        check("min_tie.a_eq_b", 64'(a_eq_b), 64'd1);
        idle_cycle();

        // Back-to-back ops then idle
        issue(2'b00, 64'd10, 64'd20);
        check("b2b0.out_valid", 64'(out_valid), 64'd1);
        check("b2b0.result",    result,         64'd30);
        issue(2'b01, 64'd10, 64'd3);
        check("b2b1.out_valid", 64'(out_valid), 64'd1);
        check("b2b1.result",    result,         64'd7);
        issue(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd4);
        check("b2b2.out_valid", 64'(out_valid), 64'd1);
        check("b2b2.result",    result,         64'd4);
        idle_cycle();
        check("b2b3.out_valid", 64'(out_valid), 64'd0);
        check("b2b3.result",    result,         64'd4);
        idle_cycle();
        check("b2b4.result",    result,         64'd4);
        check("b2b4.cover_hit", 64'(cover_hit), 64'd1);

        // Final reset clears the sticky flag
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst2.cover_hit", 64'(cover_hit), 64'd0);
        check("rst2.result",    result,         64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
